// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle shared by the FIFO read port, the adapter and the
// downstream beat consumer. The adapter takes the master view; the
// environment (FIFO plus stream sink) takes the slave view.
interface fifo_rd_stream_adapter_if #(
    parameter int IN_W  = 128,
    parameter int OUT_W = 32
);
    logic             fifo_rden;
    logic             fifo_empty;
    logic [IN_W-1:0]  fifo_rddata;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_last;

    // Adapter side: pops the FIFO and sources the beat stream.
    modport master (
        output fifo_rden,
        input  fifo_empty,
        input  fifo_rddata,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    // Environment side: the FIFO read port and the stream sink.
    modport slave (
        input  fifo_rden,
        output fifo_empty,
        output fifo_rddata,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a sync FIFO read port into a small circular word buffer and
// serializes each IN_W word into IN_W/OUT_W beats, LSB slice first.
// Reads are only issued when a buffer slot is guaranteed for the word,
// counting words already in flight through the FIFO read latency, so a
// popped word can never be dropped under downstream back-pressure.
module fifo_rd_stream_adapter #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 32,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    fifo_rd_stream_adapter_if.master  bus,
    output logic                      idle
);
    localparam int RATIO  = IN_W / OUT_W;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // Wide enough to hold occ + inflight without wrapping.
    localparam int CNT_W  = $clog2(BUF_DEPTH + RD_LAT + 1);

    // Word storage; validity of each slot is implied by occ/pointers.
    logic [IN_W-1:0]   buf_mem [BUF_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  occ_reg, occ_next;
    logic [CNT_W-1:0]  inflight_reg, inflight_next;
    logic [RD_LAT-1:0] rden_sr_reg, rden_sr_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;

    logic              rden;
    logic              tap;
    logic              push;
    logic              valid;
    logic              last_beat;
    logic              beat_acc;
    logic              pop;
    logic [IN_W-1:0]   head_word;
    logic [OUT_W-1:0]  head_slice;

    // The read-strobe history: stage 0 takes this cycle's rden, later
    // stages age it until it lines up with fifo_rddata at the tap.
    assign rden_sr_next[0] = rden;
    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rden_sr
            assign rden_sr_next[gi] = rden_sr_reg[gi-1];
        end
    endgenerate

    // Head word and its current beat slice.
    assign head_word = buf_mem[rd_ptr_reg];

    generate
        if (RATIO == 1) begin : g_single_beat
            assign head_slice = head_word;
        end else begin : g_multi_beat
            logic [OUT_W-1:0] slices [RATIO];
            for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
                assign slices[gi] = head_word[gi*OUT_W +: OUT_W];
            end
            assign head_slice = slices[beat_cnt_reg];
        end
    endgenerate

    // Read issue, credit accounting and serializer next-state. rden only
    // looks at registered counts, so m_ready never reaches fifo_rden.
    always_comb begin
        rden          = !reset && !bus.fifo_empty
                        && ((occ_reg + inflight_reg) < CNT_W'(BUF_DEPTH));
        tap           = rden_sr_reg[RD_LAT-1];
        push          = tap;
        valid         = (occ_reg != '0);
        last_beat     = (beat_cnt_reg == BEAT_W'(RATIO - 1));
        beat_acc      = valid && bus.m_ready;
        pop           = beat_acc && last_beat;

        occ_next      = occ_reg + CNT_W'(push) - CNT_W'(pop);
        inflight_next = inflight_reg + CNT_W'(rden) - CNT_W'(tap);

        wr_ptr_next   = wr_ptr_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end

        rd_ptr_next   = rd_ptr_reg;
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end

        beat_cnt_next = beat_cnt_reg;
        if (beat_acc) begin
            beat_cnt_next = last_beat ? '0 : beat_cnt_reg + 1'b1;
        end
    end

    // Outputs are pure functions of registered state, so they hold while
    // the sink stalls. m_data is forced to zero when nothing is buffered.
    always_comb begin
        bus.fifo_rden = rden;
        bus.m_valid   = valid;
        bus.m_data    = valid ? head_slice : '0;
        bus.m_last    = valid && last_beat;
        idle          = (occ_reg == '0) && (inflight_reg == '0);
    end

    // Control state; reset discards buffered and in-flight words.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
            inflight_reg <= '0;
            rden_sr_reg  <= '0;
            beat_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            occ_reg      <= occ_next;
            inflight_reg <= inflight_next;
            rden_sr_reg  <= rden_sr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Capture the returning FIFO word when its read strobe reaches the tap.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr_reg] <= bus.fifo_rddata;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: a 128->32 adapter (RD_LAT=1, BUF_DEPTH=2) and a
// 128->128 adapter (RD_LAT=2, BUF_DEPTH=4), each fed by a small FIFO model.
module tb_fifo_rd_stream_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic idle_a, idle_b;

    fifo_rd_stream_adapter_if #(.IN_W(128), .OUT_W(32))  bus_a();
    fifo_rd_stream_adapter_if #(.IN_W(128), .OUT_W(128)) bus_b();

    fifo_rd_stream_adapter #(.IN_W(128), .OUT_W(32), .RD_LAT(1), .BUF_DEPTH(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .idle(idle_a));
    fifo_rd_stream_adapter #(.IN_W(128), .OUT_W(128), .RD_LAT(2), .BUF_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .idle(idle_b));

    logic         a_empty = 1'b1;
    logic [127:0] a_rddata = '0;
    logic         a_ready = 1'b0;
    logic         b_empty = 1'b1;
    logic [127:0] b_rddata = '0;
    logic [127:0] b_stage = '0;
    logic         b_ready = 1'b0;

    assign bus_a.fifo_empty  = a_empty;
    assign bus_a.fifo_rddata = a_rddata;
    assign bus_a.m_ready     = a_ready;
    assign bus_b.fifo_empty  = b_empty;
    assign bus_b.fifo_rddata = b_rddata;
    assign bus_b.m_ready     = b_ready;

    logic [127:0] qa[$];
    logic [127:0] qb[$];

    int checks = 0;
    int failures = 0;

    // FIFO models: registered empty, data RD_LAT cycles after the strobe.
    always @(posedge clk) begin
        if (bus_a.fifo_rden && qa.size() > 0) a_rddata <= qa.pop_front();
        a_empty <= (qa.size() == 0);
    end
    always @(posedge clk) begin
        if (bus_b.fifo_rden && qb.size() > 0) b_stage <= qb.pop_front();
        b_rddata <= b_stage;
        b_empty  <= (qb.size() == 0);
    end

    function automatic logic [127:0] make_word(input int i);
        logic [127:0] w;
        for (int j = 0; j < 4; j++) w[j*32 +: 32] = {8'(i), 8'(j), 16'hC0DE};
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus_a.fifo_rden !== 1'b0) begin failures++; $display("FAIL reset_rden got=%b exp=0", bus_a.fifo_rden); end
        checks++; if (bus_a.m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus_a.m_valid); end
        checks++; if (bus_a.m_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus_a.m_data); end
        checks++; if (bus_a.m_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", bus_a.m_last); end
        checks++; if (idle_a !== 1'b1) begin failures++; $display("FAIL reset_idle_a got=%b exp=1", idle_a); end
        checks++; if (idle_b !== 1'b1 || bus_b.m_valid !== 1'b0) begin failures++; $display("FAIL reset_b idle=%b valid=%b exp idle=1 valid=0", idle_b, bus_b.m_valid); end
        @(negedge clk);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single_word();
        logic [127:0] w = 128'h33333333_22222222_11111111_00000000;
        int nrden = 0, rden_cyc = -1, fv = -1, nb = 0;
        @(negedge clk);
        a_ready = 1'b1;
        qa.push_back(w);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus_a.fifo_rden) begin nrden++; if (rden_cyc < 0) rden_cyc = c; end
            if (bus_a.m_valid && nb < 4) begin
                if (fv < 0) fv = c;
                checks++; if (bus_a.m_data !== w[nb*32 +: 32]) begin failures++; $display("FAIL single_data beat=%0d got=%h exp=%h", nb, bus_a.m_data, w[nb*32 +: 32]); end
                checks++; if (bus_a.m_last !== 1'(nb == 3)) begin failures++; $display("FAIL single_last beat=%0d got=%b exp=%b", nb, bus_a.m_last, (nb == 3)); end
                checks++; if (c != fv + nb) begin failures++; $display("FAIL single_gap beat=%0d got_cycle=%0d exp_cycle=%0d", nb, c, fv + nb); end
                nb++;
            end
        end
        checks++; if (nrden != 1) begin failures++; $display("FAIL single_rden_pulses got=%0d exp=1", nrden); end
        checks++; if (fv != rden_cyc + 2) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", fv - rden_cyc, 2); end
        checks++; if (nb != 4) begin failures++; $display("FAIL single_beats got=%0d exp=4", nb); end
        checks++; if (idle_a !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", idle_a); end
        $display("test_single_word beats=%0d rden=%0d latency=%0d", nb, nrden, fv - rden_cyc);
    endtask

    task automatic test_stream();
        logic [127:0] exp_w[$];
        logic [127:0] w;
        logic [31:0]  e;
        int nrden = 0, nb = 0, first = -1, lastc = -1, max_occ = 0;
        @(negedge clk);
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin w = make_word(16 + i); qa.push_back(w); exp_w.push_back(w); end
        for (int c = 0; c < 100 && nb < 32; c++) begin
            @(negedge clk); #1;
            if (bus_a.fifo_rden) nrden++;
            if (int'(dut_a.occ_reg) > max_occ) max_occ = int'(dut_a.occ_reg);
            if (bus_a.m_valid) begin
                if (first < 0) first = c;
                lastc = c;
                w = exp_w[nb/4];
                e = w[(nb%4)*32 +: 32];
                checks++; if (bus_a.m_data !== e || bus_a.m_last !== 1'(nb % 4 == 3)) begin failures++; $display("FAIL stream_beat n=%0d got=%h/%b exp=%h/%b", nb, bus_a.m_data, bus_a.m_last, e, (nb % 4 == 3)); end
                nb++;
            end
        end
        checks++; if (nb != 32) begin failures++; $display("FAIL stream_count got=%0d exp=32", nb); end
        checks++; if (lastc - first != 31) begin failures++; $display("FAIL stream_gapless span=%0d exp=31", lastc - first); end
        checks++; if (nrden != 8) begin failures++; $display("FAIL stream_rden got=%0d exp=8", nrden); end
        checks++; if (max_occ > 2) begin failures++; $display("FAIL stream_occ max=%0d exp<=2", max_occ); end
        @(negedge clk); #1;
        checks++; if (idle_a !== 1'b1 || bus_a.m_valid !== 1'b0) begin failures++; $display("FAIL stream_drain idle=%b valid=%b exp 1/0", idle_a, bus_a.m_valid); end
        $display("test_stream beats=%0d span=%0d rden=%0d max_occ=%0d", nb, lastc - first, nrden, max_occ);
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_w[$];
        logic [127:0] w;
        logic [31:0]  e;
        int nrden = 0, nb = 0;
        @(negedge clk);
        a_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin w = make_word(32 + i); qa.push_back(w); exp_w.push_back(w); end
        w = exp_w[0];
        e = w[31:0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (bus_a.fifo_rden) nrden++;
            if (c >= 3) begin
                checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== e || bus_a.m_last !== 1'b0) begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h/%b exp=1/%h/0", c, bus_a.m_valid, bus_a.m_data, bus_a.m_last, e); end
            end
        end
        checks++; if (nrden != 2) begin failures++; $display("FAIL stall_rden got=%0d exp=2", nrden); end
        for (int c = 0; c < 100 && nb < 32; c++) begin
            @(negedge clk);
            a_ready = 1'b1;
            #1;
            if (bus_a.fifo_rden) nrden++;
            if (bus_a.m_valid) begin
                w = exp_w[nb/4];
                e = w[(nb%4)*32 +: 32];
                checks++; if (bus_a.m_data !== e) begin failures++; $display("FAIL release_beat n=%0d got=%h exp=%h", nb, bus_a.m_data, e); end
                nb++;
            end
        end
        checks++; if (nb != 32) begin failures++; $display("FAIL release_count got=%0d exp=32", nb); end
        @(negedge clk); #1;
        checks++; if (nrden != 8 || bus_a.m_valid !== 1'b0) begin failures++; $display("FAIL release_end rden=%0d valid=%b exp 8/0", nrden, bus_a.m_valid); end
        $display("test_backpressure beats=%0d rden=%0d", nb, nrden);
    endtask

    task automatic test_random();
        logic [31:0]  exp_d[$];
        logic         exp_l[$];
        logic [127:0] w;
        logic [31:0]  ed, pd = '0;
        logic         el, pv = 1'b0, pr = 1'b0, pl = 1'b0;
        int pushed = 0, got = 0, bad_rden = 0;
        for (int c = 0; c < 5000 && got < 400; c++) begin
            @(negedge clk);
            if (pushed < 100 && $urandom_range(0, 7) == 0) begin
                w = {$urandom, $urandom, $urandom, $urandom};
                qa.push_back(w);
                for (int j = 0; j < 4; j++) begin exp_d.push_back(w[j*32 +: 32]); exp_l.push_back(j == 3); end
                pushed++;
            end
            a_ready = 1'($urandom_range(0, 1));
            #1;
            if (bus_a.fifo_rden && bus_a.fifo_empty) bad_rden++;
            if (pv && !pr) begin
                checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== pd || bus_a.m_last !== pl) begin failures++; $display("FAIL rand_stable c=%0d got=%b/%h/%b exp=1/%h/%b", c, bus_a.m_valid, bus_a.m_data, bus_a.m_last, pd, pl); end
            end
            if (bus_a.m_valid && a_ready) begin
                ed = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hDEAD_BEEF;
                el = (exp_l.size() > 0) ? exp_l.pop_front() : 1'b0;
                checks++; if (bus_a.m_data !== ed || bus_a.m_last !== el) begin failures++; $display("FAIL rand_beat n=%0d got=%h/%b exp=%h/%b", got, bus_a.m_data, bus_a.m_last, ed, el); end
                got++;
            end
            pv = bus_a.m_valid; pr = a_ready; pd = bus_a.m_data; pl = bus_a.m_last;
        end
        checks++; if (got != 400) begin failures++; $display("FAIL rand_count got=%0d exp=400", got); end
        checks++; if (bad_rden != 0) begin failures++; $display("FAIL rand_rden_empty got=%0d exp=0", bad_rden); end
        a_ready = 1'b1;
        $display("test_random words=%0d beats=%0d", pushed, got);
    endtask

    task automatic test_reset_mid();
        logic [127:0] exp_w[$];
        logic [127:0] w;
        logic [31:0]  e;
        int acc = 0, nb = 0, n_exp;
        bit found = 0;
        @(negedge clk);
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin w = make_word(64 + i); qa.push_back(w); end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (bus_a.m_valid && acc == 14) begin found = 1; break; end
            if (bus_a.m_valid && a_ready) acc++;
        end
        checks++; if (!found) begin failures++; $display("FAIL rstmid_reach got_beats=%0d exp=14", acc); end
        checks++; if (int'(dut_a.occ_reg) != 2) begin failures++; $display("FAIL rstmid_occ got=%0d exp=2", int'(dut_a.occ_reg)); end
        reset = 1'b1;
        #1;
        checks++; if (bus_a.fifo_rden !== 1'b0) begin failures++; $display("FAIL rstmid_rden got=%b exp=0", bus_a.fifo_rden); end
        exp_w = qa;
        n_exp = exp_w.size() * 4;
        checks++; if (exp_w.size() != 3) begin failures++; $display("FAIL rstmid_popped remaining=%0d exp=3", exp_w.size()); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (bus_a.m_valid !== 1'b0 || idle_a !== 1'b1) begin failures++; $display("FAIL rstmid_clear valid=%b idle=%b exp 0/1", bus_a.m_valid, idle_a); end
        for (int c = 0; c < 100 && nb < n_exp; c++) begin
            @(negedge clk); #1;
            if (bus_a.m_valid) begin
                w = exp_w[nb/4];
                e = w[(nb%4)*32 +: 32];
                checks++; if (bus_a.m_data !== e) begin failures++; $display("FAIL rstmid_beat n=%0d got=%h exp=%h", nb, bus_a.m_data, e); end
                nb++;
            end
        end
        checks++; if (nb != n_exp) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", nb, n_exp); end
        $display("test_reset_mid beats_after_reset=%0d", nb);
    endtask

    task automatic test_ratio1();
        logic [127:0] exp_w[$];
        logic [127:0] w;
        int nb = 0, rc = -1, fv = -1, max_occ = 0;
        @(negedge clk);
        b_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin w = make_word(128 + i); qb.push_back(w); exp_w.push_back(w); end
        for (int c = 0; c < 100 && nb < 16; c++) begin
            @(negedge clk); #1;
            if (bus_b.fifo_rden && rc < 0) rc = c;
            if (int'(dut_b.occ_reg) > max_occ) max_occ = int'(dut_b.occ_reg);
            if (bus_b.m_valid) begin
                if (fv < 0) fv = c;
                w = exp_w[nb];
                checks++; if (bus_b.m_data !== w || bus_b.m_last !== 1'b1) begin failures++; $display("FAIL r1_beat n=%0d got=%h/%b exp=%h/1", nb, bus_b.m_data, bus_b.m_last, w); end
                checks++; if (c != fv + nb) begin failures++; $display("FAIL r1_gap n=%0d got_cycle=%0d exp_cycle=%0d", nb, c, fv + nb); end
                nb++;
            end
        end
        checks++; if (nb != 16) begin failures++; $display("FAIL r1_count got=%0d exp=16", nb); end
        checks++; if (fv != rc + 3) begin failures++; $display("FAIL r1_latency got=%0d exp=3", fv - rc); end
        checks++; if (max_occ > 4) begin failures++; $display("FAIL r1_occ max=%0d exp<=4", max_occ); end
        $display("test_ratio1 beats=%0d latency=%0d", nb, fv - rc);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_ratio1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
